// File: rtl/icache_sram_initiator.sv
// Initiator for the single-port instruction SRAM: turns a valid/ready request channel into one
// registered SRAM cycle, waits READ_LATENCY, returns data. Option: ICACHE_SRAM_INIT_MISALIGN_ERR_EN.
module icache_sram_initiator #(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_WMASKS   = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH+1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_WMASKS-1:0]   req_wmask_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  output logic [NUM_WMASKS-1:0]   sram_wmask_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i
`ifdef ICACHE_SRAM_INIT_MISALIGN_ERR_EN
  ,
  output logic                    rsp_err_o
`endif
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [2:0] LatInit = 3'(READ_LATENCY - 1);

  state_e                  r_state;
  logic [2:0]              r_cnt;
  logic                    r_csb;
  logic                    r_web;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [NUM_WMASKS-1:0]   r_wmask;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    w_misaligned;

`ifdef ICACHE_SRAM_INIT_MISALIGN_ERR_EN
  logic r_rsp_err;
  assign w_misaligned = (req_addr_i[1:0] != 2'b00);
  assign rsp_err_o    = r_rsp_err;
`else
  logic w_unused_addr_lsb;
  assign w_misaligned      = 1'b0;
  assign w_unused_addr_lsb = ^req_addr_i[1:0];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_cnt       <= 3'd0;
      r_csb       <= 1'b1;
      r_web       <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef ICACHE_SRAM_INIT_MISALIGN_ERR_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid_i) begin
            r_addr  <= req_addr_i[ADDR_WIDTH+1:2];
            r_wdata <= req_wdata_i;
            r_wmask <= req_wmask_i;
            if (w_misaligned) begin
              // Misaligned: answer with an error, never touch the SRAM.
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
`ifdef ICACHE_SRAM_INIT_MISALIGN_ERR_EN
              r_rsp_err   <= 1'b1;
`endif
              r_state     <= StResp;
            end else begin
              r_csb   <= 1'b0;
              r_web   <= ~req_we_i;
`ifdef ICACHE_SRAM_INIT_MISALIGN_ERR_EN
              r_rsp_err <= 1'b0;
`endif
              r_state <= StAccess;
            end
          end
        end
        StAccess: begin
          r_csb <= 1'b1;
          r_web <= 1'b1;
          // r_web still holds the issued cycle type: low means write.
          if (!r_web) begin
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_cnt   <= LatInit;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (r_cnt == 3'd0) begin
            r_rsp_rdata <= sram_rdata_i;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (r_state == StIdle);
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_rdata_o  = r_rsp_rdata;
  assign sram_csb_o   = r_csb;
  assign sram_web_o   = r_web;
  assign sram_addr_o  = r_addr;
  assign sram_wdata_o = r_wdata;
  assign sram_wmask_o = r_wmask;

endmodule
